// File: rtl/msrv32_pkg.sv
// Shared MSRV32 definitions used by the fetch sequencer.
package msrv32_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_ERR
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/msrv32_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues valid/ready requests
// to instruction memory and presents captured words to the instruction mux.
module msrv32_fetch_ctrl
    import msrv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] pc_in,
    input  logic        redirect_in,
    input  logic        stall_in,
    output logic [31:0] imaddr_out,
    output logic        imreq_out,
    input  logic        imready_in,
    input  logic [31:0] imdata_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid_out,
    output logic        flush_out,
    output logic        fetch_err_out
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

    fetch_state_t state, state_n;
    logic [31:0]  fetch_pc, fetch_pc_n;
    logic [31:0]  imaddr_n, instr_n, pc_n;
    logic         drop, drop_n;
    logic         imreq_n, valid_n, err_n;
    logic [7:0]   wait_cnt, wait_cnt_n;
    logic [31:0]  redirect_pc;
    logic         unused_pc_bits;

    assign redirect_pc    = {pc_in[31:2], 2'b00};
    assign unused_pc_bits = ^pc_in[1:0];
    assign flush_out      = ~instr_valid_out;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state           <= ST_RESET;
            fetch_pc        <= RESET_PC;
            drop            <= 1'b0;
            wait_cnt        <= 8'd0;
            imaddr_out      <= RESET_PC;
            imreq_out       <= 1'b0;
            instr_out       <= NOP_INSTR;
            pc_out          <= RESET_PC;
            instr_valid_out <= 1'b0;
            fetch_err_out   <= 1'b0;
        end else begin
            state           <= state_n;
            fetch_pc        <= fetch_pc_n;
            drop            <= drop_n;
            wait_cnt        <= wait_cnt_n;
            imaddr_out      <= imaddr_n;
            imreq_out       <= imreq_n;
            instr_out       <= instr_n;
            pc_out          <= pc_n;
            instr_valid_out <= valid_n;
            fetch_err_out   <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        drop_n     = drop;
        wait_cnt_n = wait_cnt;
        instr_n    = instr_out;
        pc_n       = pc_out;
        err_n      = fetch_err_out;
        valid_n    = instr_valid_out && stall_in;

        case (state)
            ST_RESET: state_n = ST_REQ;
            ST_REQ, ST_WAIT: begin
                if (imready_in) begin
                    wait_cnt_n = 8'd0;
                    if (drop || redirect_in) begin
                        // Response belongs to a superseded PC: throw it away.
                        drop_n  = 1'b0;
                        state_n = ST_REQ;
                    end else begin
                        instr_n    = imdata_in;
                        pc_n       = fetch_pc;
                        valid_n    = 1'b1;
                        fetch_pc_n = fetch_pc + 32'd4;
                        state_n    = stall_in ? ST_HOLD : ST_REQ;
                    end
                end else if (redirect_in) begin
                    // Memory still owes a response, so keep the request alive.
                    drop_n  = 1'b1;
                    state_n = ST_WAIT;
                end else if (state == ST_REQ) begin
                    wait_cnt_n = 8'd1;
                    state_n    = ST_WAIT;
                end else if (wait_cnt >= TIMEOUT_CNT) begin
                    wait_cnt_n = 8'd0;
                    drop_n     = 1'b0;
                    state_n    = ST_ERR;
                end else begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            ST_HOLD: if (!stall_in) state_n = ST_REQ;
            ST_ERR:  valid_n = 1'b0;
            default: state_n = ST_RESET;
        endcase

        if (redirect_in && state != ST_RESET) begin
            fetch_pc_n = redirect_pc;
            valid_n    = 1'b0;
            err_n      = 1'b0;
            wait_cnt_n = 8'd0;
            if (state == ST_HOLD || state == ST_ERR) state_n = ST_REQ;
        end

        if (state_n == ST_ERR) begin
            valid_n = 1'b0;
            err_n   = 1'b1;
        end

        imreq_n  = (state_n == ST_REQ) || (state_n == ST_WAIT);
        imaddr_n = (state_n == ST_WAIT) ? imaddr_out : fetch_pc_n;
    end

endmodule

// File: doc/msrv32_fetch_ctrl.md
# msrv32_fetch_ctrl

Instruction-fetch sequencer for the MSRV32 core.
- Owns the fetch PC and drives a valid/ready request to instruction memory.
- Captures the returned word and presents it, with its PC, to the instruction mux.
- Generates that mux's flush input, so a NOP (32'h0000_0013) is issued while a redirect is in progress or no instruction is available.
- Sits between the PC mux / branch-trap logic and `msrv32_instruction_mux`.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- TIMEOUT_CYCLES, 16, wait cycles in WAIT before a fetch error is flagged (range 2..255)

Ports:
- clk_in  input  1  clock; all state changes on rising edge
- rst_in  input  1  reset, synchronous, active-low
- pc_in  input  32  redirect target from PC mux; bits [1:0] ignored
- redirect_in  input  1  branch-taken/jump/trap; load pc_in as fetch PC
- stall_in  input  1  downstream stall; hold presented instruction
- imaddr_out  output  32  instruction memory address, word-aligned
- imreq_out  output  1  request valid
- imready_in  input  1  memory has returned imdata_in this cycle
- imdata_in  input  32  instruction word from memory
- instr_out  output  32  captured instruction, to instr_in of instruction mux
- pc_out  output  32  PC of instr_out
- instr_valid_out  output  1  instr_out is a real instruction
- flush_out  output  1  to flush_in of instruction mux; equals ~instr_valid_out
- fetch_err_out  output  1  sticky fetch-timeout flag

## Operation
States: RESET, REQ, WAIT, HOLD, ERR. Internal registers:
- fetch_pc
- drop flag: the in-flight response is discarded
- 8-bit wait counter

- **RESET** (entered while rst_in=0, stays for 1 cycle after release)
  - Reset values: imreq_out=0, imaddr_out=RESET_PC, fetch_pc=RESET_PC, instr_out=32'h0000_0013, pc_out=RESET_PC, instr_valid_out=0, flush_out=1, fetch_err_out=0, drop=0, counter=0.
  - Goes to REQ.
- **REQ**
  - imreq_out=1, imaddr_out=fetch_pc.
  - imready_in=1 → capture.
  - Otherwise → WAIT, counter=1.
- **WAIT**
  - imreq_out and imaddr_out are held stable until imready_in=1; the counter increments each cycle.
  - imready_in=1 → capture.
  - Counter reaching TIMEOUT_CYCLES → ERR.
- **Capture** (on the imready_in edge)
  - If drop=1: discard the data, clear drop, and go to REQ at fetch_pc. The redirect already loaded fetch_pc.
  - Otherwise: instr_out=imdata_in, pc_out=fetch_pc, instr_valid_out=1, fetch_pc+=4 (mod 2^32, wraps at 32'hFFFF_FFFC → 0).
  - Then go to HOLD if stall_in=1, else to REQ. This gives back-to-back fetch.
- **HOLD**
  - imreq_out=0; instr_out, pc_out and instr_valid_out are held.
  - stall_in=0 → REQ.
- **ERR**
  - imreq_out=0, fetch_err_out=1, instr_valid_out=0.
  - Left only by redirect_in (trap vector) or reset.
- **Presented instruction is consumed** on any cycle where instr_valid_out=1 and stall_in=0. On that edge instr_valid_out drops to 0, unless a new capture occurs on the same edge.
- **redirect_in=1**, any state except RESET (highest priority over stall_in and imready_in):
  - fetch_pc ← {pc_in[31:2],2'b00}; instr_valid_out ← 0.
  - Clear fetch_err_out and the counter.
  - In WAIT without imready_in: stay in WAIT with the old address stable and set drop=1. The request is never abandoned.
  - In REQ/WAIT with imready_in=1: the returned data is discarded; next state REQ at the new PC.
  - In HOLD or ERR: next state REQ.

## Timing
- Zero-wait memory: one instruction per cycle. imreq_out stays high in REQ, and capture occurs every edge.
- Latency: reset release → first imreq_out in cycle 2 → instr_valid_out the cycle after imready_in.
- Redirect: flush_out is high from the cycle after redirect_in until the first target instruction is captured. Minimum bubble is 1 cycle with a zero-wait memory.
- Outputs are all registered; there is no combinational path from any input to any output.
- rst_in=0 mid-WAIT drops imreq_out the following edge. Instruction memory must tolerate the abandoned request.

## Structure
- Shared package `msrv32_pkg`:
  - state enum
  - NOP constant 32'h0000_0013
  - reset PC default
- No sub-module; a single FSM plus registers.

## Test plan
- **Reset, zero-wait memory:** rst_in low 3 cycles, imready_in tied 1, memory returns addr-tagged words → imaddr_out 0,4,8,… on consecutive cycles; instr_valid_out first high 3 cycles after release; flush_out low thereafter.
- **Wait states:** imready_in delayed 3 cycles per request → imaddr_out stable during WAIT; one instruction every 4 cycles; pc_out matches each word's address.
- **Redirect during WAIT:** redirect_in with pc_in=32'h0000_0103 while waiting on 0x8 → address 0x8 held until ready; that data discarded; next request at 0x100; flush_out high until the 0x100 word is presented.
- **Stall and redirect:** stall_in held 5 cycles with instruction at 0x20 presented → instr_out and pc_out unchanged, imreq_out=0. Assert redirect_in in the 3rd stall cycle → valid drops next cycle; fetch resumes at target.
- **Timeout:** imready_in never asserted, TIMEOUT_CYCLES=16 → fetch_err_out high after 16 WAIT cycles and stays high; redirect_in to 0x80 clears it and fetches 0x80.
- **Wrap-around:** redirect to 32'hFFFF_FFFC → next fetch address 0x0.
